// File: rtl/sel_counter_table_if.sv
// Lookup/update/flush bundle for the selector counter table.
interface sel_counter_table_if #(
   parameter int unsigned CNT_W = 2,
   parameter int unsigned IDX_W = 6
);
   logic             rd_en;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_valid;
   logic [CNT_W-1:0] rd_cnt;
   logic             rd_sel;
   logic             upd_en;
   logic [IDX_W-1:0] upd_idx;
   logic             p1_ok;
   logic             p2_ok;
   logic             flush;
   logic             busy;
   logic             wr_en;

   modport master (
      output rd_en, rd_idx, upd_en, upd_idx, p1_ok, p2_ok, flush,
      input  rd_valid, rd_cnt, rd_sel, busy, wr_en
   );

   modport slave (
      input  rd_en, rd_idx, upd_en, upd_idx, p1_ok, p2_ok, flush,
      output rd_valid, rd_cnt, rd_sel, busy, wr_en
   );
endinterface

// File: rtl/sel_counter_table.sv
// Table of saturating selector counters choosing between predictors P1 and P2.
// Define SEL_BYPASS_EN to forward a same-cycle same-index update into the lookup.
module sel_counter_table #(
   parameter int unsigned CNT_W    = 2,
   parameter int unsigned IDX_W    = 6,
   parameter int unsigned INIT_VAL = (1 << (CNT_W - 1)) - 1
) (
   input logic               clk,
   input logic               reset_n,
   sel_counter_table_if.slave bus
);
   localparam int unsigned      DEPTH    = 1 << IDX_W;
   localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_VAL);
   localparam logic [CNT_W-1:0] MAX_C    = {CNT_W{1'b1}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [CNT_W-1:0] table_q [DEPTH];

   logic             rd_valid_q, rd_sel_q, wr_en_q, busy_q;
   logic [CNT_W-1:0] rd_cnt_q;

   logic             clearing, upd_go;
   logic [CNT_W-1:0] upd_old, upd_new, rd_val;

   assign clearing = (state_q == CLEAR);

   // Flush sequencer state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         IDLE: begin
            if (bus.flush) begin
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end
         end
         CLEAR: begin
            clr_ptr_d = clr_ptr_q + IDX_W'(1);
            if (clr_ptr_q == LAST_IDX) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Saturating update value and lookup source selection
   always_comb begin
      upd_old = table_q[bus.upd_idx];
      upd_new = upd_old;
      if (bus.p2_ok && !bus.p1_ok && (upd_old != MAX_C))
         upd_new = upd_old + CNT_W'(1);
      else if (bus.p1_ok && !bus.p2_ok && (upd_old != '0))
         upd_new = upd_old - CNT_W'(1);
      upd_go = bus.upd_en && !clearing;
      rd_val = table_q[bus.rd_idx];
`ifdef SEL_BYPASS_EN
      if (upd_go && (bus.upd_idx == bus.rd_idx)) rd_val = upd_new;
`endif
      if (clearing) rd_val = INIT_C;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) table_q[IDX_W'(k)] <= INIT_C;
      end else if (clearing) begin
         table_q[clr_ptr_q] <= INIT_C;
      end else if (upd_go) begin
         table_q[bus.upd_idx] <= upd_new;
      end
   end

   // Registered lookup result and status
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid_q <= 1'b0;
         rd_cnt_q   <= INIT_C;
         rd_sel_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            rd_cnt_q <= rd_val;
            rd_sel_q <= rd_val[CNT_W-1];
         end
         wr_en_q <= upd_go && (upd_new != upd_old);
         busy_q  <= (state_d == CLEAR);
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_cnt   = rd_cnt_q;
   assign bus.rd_sel   = rd_sel_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sel_counter_table.sv
// Bench for sel_counter_table: three configurations checked against a table-level model.
module tb_sel_counter_table;
   localparam int NI = 3;
   localparam int DEP [NI] = '{64, 8, 8};
   localparam int INI [NI] = '{1, 1, 3};
   localparam int MXV [NI] = '{3, 3, 7};
   localparam int HLF [NI] = '{2, 2, 4};
   localparam int WEXP [5] = '{4, 5, 6, 7, 7};
`ifdef SEL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic       rd_en_t [NI], upd_en_t [NI], p1_t [NI], p2_t [NI], flush_t [NI];
   logic [7:0] rd_idx_t [NI], upd_idx_t [NI];
   logic [31:0] o_valid [NI], o_cnt [NI], o_sel [NI], o_busy [NI], o_wr [NI];

   int n_cmp = 0;
   int n_bad = 0;

   sel_counter_table_if #(.CNT_W(2), .IDX_W(6)) if0 ();
   sel_counter_table_if #(.CNT_W(2), .IDX_W(3)) if1 ();
   sel_counter_table_if #(.CNT_W(3), .IDX_W(3)) if2 ();

   sel_counter_table #(.CNT_W(2), .IDX_W(6)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
   sel_counter_table #(.CNT_W(2), .IDX_W(3)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
   sel_counter_table #(.CNT_W(3), .IDX_W(3), .INIT_VAL(3)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

`define HOOK(IFN, N, IW) \
   assign IFN.rd_en   = rd_en_t[N]; \
   assign IFN.rd_idx  = rd_idx_t[N][IW-1:0]; \
   assign IFN.upd_en  = upd_en_t[N]; \
   assign IFN.upd_idx = upd_idx_t[N][IW-1:0]; \
   assign IFN.p1_ok   = p1_t[N]; \
   assign IFN.p2_ok   = p2_t[N]; \
   assign IFN.flush   = flush_t[N]; \
   assign o_valid[N]  = 32'(IFN.rd_valid); \
   assign o_cnt[N]    = 32'(IFN.rd_cnt); \
   assign o_sel[N]    = 32'(IFN.rd_sel); \
   assign o_busy[N]   = 32'(IFN.busy); \
   assign o_wr[N]     = 32'(IFN.wr_en);

   `HOOK(if0, 0, 6)
   `HOOK(if1, 1, 3)
   `HOOK(if2, 2, 3)
`undef HOOK

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Table model: counters in an array; a flush refills it at once and then
   // counts down the busy window during which updates are dropped.
   int ent [NI][64];
   int left [NI];
   int m_valid [NI], m_cnt [NI], m_wr [NI];

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 64; k++) ent[i][k] = INI[i];
            left[i] = 0; m_valid[i] = 0; m_cnt[i] = INI[i]; m_wr[i] = 0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            int old, nv;
            bit wb;
            wb  = left[i] > 0;
            old = ent[i][upd_idx_t[i]];
            nv  = old;
            if (p2_t[i] && !p1_t[i]) nv = (old + 1 > MXV[i]) ? MXV[i] : old + 1;
            else if (p1_t[i] && !p2_t[i]) nv = (old - 1 < 0) ? 0 : old - 1;
            if (rd_en_t[i]) begin
               m_valid[i] = 1;
               if (wb) m_cnt[i] = INI[i];
               else if (upd_en_t[i] && upd_idx_t[i] == rd_idx_t[i]) m_cnt[i] = BYP ? nv : old;
               else m_cnt[i] = ent[i][rd_idx_t[i]];
            end else m_valid[i] = 0;
            if (upd_en_t[i] && !wb) begin
               m_wr[i] = (nv != old) ? 1 : 0;
               ent[i][upd_idx_t[i]] = nv;
            end else m_wr[i] = 0;
            if (wb) left[i]--;
            else if (flush_t[i]) begin
               left[i] = DEP[i];
               for (int k = 0; k < 64; k++) ent[i][k] = INI[i];
            end
         end
      end
   end

   // Cycle compare against the model
   initial forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("cyc%0d_valid", i), o_valid[i], 32'(m_valid[i]));
            chk($sformatf("cyc%0d_cnt", i), o_cnt[i], 32'(m_cnt[i]));
            chk($sformatf("cyc%0d_sel", i), o_sel[i], (m_cnt[i] >= HLF[i]) ? 32'd1 : 32'd0);
            chk($sformatf("cyc%0d_busy", i), o_busy[i], (left[i] > 0) ? 32'd1 : 32'd0);
            chk($sformatf("cyc%0d_wr", i), o_wr[i], 32'(m_wr[i]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr_inputs();
      for (int i = 0; i < NI; i++) begin
         rd_en_t[i] = 0; upd_en_t[i] = 0; p1_t[i] = 0; p2_t[i] = 0; flush_t[i] = 0;
         rd_idx_t[i] = '0; upd_idx_t[i] = '0;
      end
   endtask

   task automatic upd(input int i, input int idx, input bit p1, input bit p2);
      upd_en_t[i] = 1; upd_idx_t[i] = 8'(idx); p1_t[i] = p1; p2_t[i] = p2;
      step();
      upd_en_t[i] = 0;
   endtask

   task automatic rd(input int i, input int idx);
      rd_en_t[i] = 1; rd_idx_t[i] = 8'(idx);
      step();
      rd_en_t[i] = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      int nb;
      clr_inputs();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk("rst_valid", o_valid[i], 0);
         chk("rst_cnt", o_cnt[i], 32'(INI[i]));
         chk("rst_busy", o_busy[i], 0);
      end
      reset_n = 1'b1;

      rd(0, 5);
      chk("first_rd_valid", o_valid[0], 1);
      chk("first_rd_cnt", o_cnt[0], 1);

      // saturation at the top
      upd(0, 5, 0, 1); chk("sat_wr1", o_wr[0], 1);
      upd(0, 5, 0, 1); chk("sat_wr2", o_wr[0], 1);
      upd(0, 5, 0, 1); chk("sat_wr3", o_wr[0], 0);
      rd(0, 5); chk("sat_sel", o_sel[0], 1); chk("sat_cnt", o_cnt[0], 3);

      // floor and no-change
      upd(0, 0, 1, 0); chk("floor_wr_dec", o_wr[0], 1);
      upd(0, 0, 1, 0); chk("floor_wr_sat", o_wr[0], 0);
      upd(0, 0, 1, 1); chk("floor_wr_same", o_wr[0], 0);
      rd(0, 0); chk("floor_cnt", o_cnt[0], 0);
      step(); chk("hold_valid", o_valid[0], 0); chk("hold_cnt", o_cnt[0], 0);

      // same-index collision
      rd_en_t[0] = 1; rd_idx_t[0] = 8'd9;
      upd_en_t[0] = 1; upd_idx_t[0] = 8'd9; p1_t[0] = 0; p2_t[0] = 1;
      step();
      rd_en_t[0] = 0; upd_en_t[0] = 0;
      chk("coll_cnt", o_cnt[0], BYP ? 32'd2 : 32'd1);
      chk("coll_wr", o_wr[0], 1);
      rd(0, 9); chk("coll_next", o_cnt[0], 2);

      // different-index lookup and update together
      rd_en_t[0] = 1; rd_idx_t[0] = 8'd5;
      upd_en_t[0] = 1; upd_idx_t[0] = 8'd9; p1_t[0] = 1; p2_t[0] = 0;
      step();
      rd_en_t[0] = 0; upd_en_t[0] = 0;
      chk("indep_cnt", o_cnt[0], 3);
      rd(0, 9); chk("indep_upd", o_cnt[0], 1);

      // flush on the 8-entry table
      upd(1, 2, 0, 1); upd(1, 7, 1, 0);
      rd(1, 2); chk("pre_flush", o_cnt[1], 2);
      flush_t[1] = 1; step(); flush_t[1] = 0;
      nb = (o_busy[1] == 1) ? 1 : 0;
      upd(1, 3, 0, 1);
      chk("busy_upd_wr", o_wr[1], 0);
      if (o_busy[1] == 1) nb++;
      rd_en_t[1] = 1; rd_idx_t[1] = 8'd2; flush_t[1] = 1;
      step();
      rd_en_t[1] = 0; flush_t[1] = 0;
      chk("busy_rd", o_cnt[1], 1);
      if (o_busy[1] == 1) nb++;
      for (int c = 0; c < 20 && o_busy[1] == 1; c++) begin
         step();
         if (o_busy[1] == 1) nb++;
      end
      chk("flush_busy_cycles", 32'(nb), 8);
      for (int k = 0; k < 8; k++) begin
         rd(1, k); chk("flush_ent", o_cnt[1], 1);
      end

      // 3-bit counters
      for (int n = 0; n < 5; n++) begin
         upd(2, 4, 0, 1);
         rd(2, 4);
         chk("w3_cnt", o_cnt[2], 32'(WEXP[n]));
         chk("w3_sel", o_sel[2], 1);
      end

      // asynchronous reset during flush, lookup and a write
      flush_t[0] = 1; rd_en_t[0] = 1; rd_idx_t[0] = 8'd5;
      step();
      flush_t[0] = 0;
      upd_en_t[2] = 1; upd_idx_t[2] = 8'd1; p1_t[2] = 0; p2_t[2] = 1;
      step();
      chk("pre_rst_busy", o_busy[0], 1);
      chk("pre_rst_valid", o_valid[0], 1);
      chk("pre_rst_wr", o_wr[2], 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", o_busy[0], 0);
      chk("arst_valid", o_valid[0], 0);
      chk("arst_cnt", o_cnt[0], 1);
      chk("arst_sel", o_sel[0], 0);
      chk("arst_wr", o_wr[2], 0);
      chk("arst_cnt_w3", o_cnt[2], 3);
      clr_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < DEP[i]; k++) begin
            rd(i, k);
            chk("post_rst_ent", o_cnt[i], 32'(INI[i]));
         end
      end
      chk("post_rst_busy", o_busy[0], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
